operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader_pkg.sv | 28 ++
 rtl/operand_loader_if.sv | 26 ++
 rtl/operand_loader.sv | 160 ++++++++++++++++
 tb/tb_operand_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: FSM encoding, opcodes, frame header
// and error cause codes.
package operand_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_DIV = 2'b11;

    localparam logic [3:0] HDR_NIBBLE = 4'hA;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_HDR  = 2'b01;
    localparam logic [1:0] ERR_DIV0 = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    function automatic logic hdr_ok(input logic [3:0] nibble);
        return (nibble == HDR_NIBBLE);
    endfunction

endpackage

// File: rtl/operand_loader_if.sv
// Byte-stream input, operand/opcode issue bus and error report of the operand loader.
interface operand_loader_if #(
    parameter int in_data_width = 16,
    parameter int BYTE_W        = 8
);
    logic [BYTE_W-1:0]               rx_data;
    logic                            rx_valid;
    logic                            rx_ready;
    logic signed [in_data_width-1:0] a;
    logic signed [in_data_width-1:0] b;
    logic [1:0]                      alu_fun;
    logic                            arith_enable;
    logic                            arith_done;
    logic                            err;
    logic [1:0]                      err_code;

    modport master (
        input  rx_data, rx_valid, arith_done,
        output rx_ready, a, b, alu_fun, arith_enable, err, err_code
    );

    modport slave (
        output rx_data, rx_valid, arith_done,
        input  rx_ready, a, b, alu_fun, arith_enable, err, err_code
    );
endinterface

// File: rtl/operand_loader.sv
// Assembles a 5-byte CMD/A/B frame from the byte stream, issues it to the arithmetic
// stage with a one-cycle strobe and supervises completion with a bounded wait.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int in_data_width = 16,
    parameter int BYTE_W        = 8,
    parameter int WAIT_MAX      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    operand_loader_if.master     bus
);

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_MAX - 1);

    state_e                     state_q, state_d;
    logic [1:0]                 bcnt_q, bcnt_d;
    logic [WCNT_W-1:0]          wcnt_q, wcnt_d;
    logic [1:0]                 op_q, op_d;
    logic [BYTE_W-1:0]          a_lo_q, a_lo_d;
    logic [BYTE_W-1:0]          a_hi_q, a_hi_d;
    logic [BYTE_W-1:0]          b_lo_q, b_lo_d;
    logic [in_data_width-1:0]   a_q, a_d;
    logic [in_data_width-1:0]   b_q, b_d;
    logic [1:0]                 alu_q, alu_d;
    logic                       en_q, en_d;
    logic                       err_q, err_d;
    logic [1:0]                 code_q, code_d;
    logic                       rdy_q, rdy_d;
    logic                       accept_s;

    assign accept_s = bus.rx_valid && rdy_q;

    // Next-state, frame assembly, issue and error decisions.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        op_d    = op_q;
        a_lo_d  = a_lo_q;
        a_hi_d  = a_hi_q;
        b_lo_d  = b_lo_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        err_d   = 1'b0;
        code_d  = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                bcnt_d = 2'd0;
                wcnt_d = '0;
                if (accept_s) begin
                    if (hdr_ok(bus.rx_data[BYTE_W-1 -: 4])) begin
                        op_d    = bus.rx_data[1:0];
                        state_d = ST_LOAD;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_HDR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    bcnt_d = bcnt_q + 2'd1;
                    case (bcnt_q)
                        2'd0: a_lo_d = bus.rx_data;
                        2'd1: a_hi_d = bus.rx_data;
                        2'd2: b_lo_d = bus.rx_data;
                        2'd3: begin
                            // B_HI goes straight from the bus into b; no shadow needed.
                            if ((op_q == ALU_DIV) && ({bus.rx_data, b_lo_q} == '0)) begin
                                err_d   = 1'b1;
                                code_d  = ERR_DIV0;
                                state_d = ST_IDLE;
                            end else begin
                                a_d     = {a_hi_q, a_lo_q};
                                b_d     = {bus.rx_data, b_lo_q};
                                alu_d   = op_q;
                                state_d = ST_ISSUE;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_ISSUE: begin
                wcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.arith_done) begin
                    wcnt_d  = '0;
                    state_d = ST_IDLE;
                end else if (wcnt_q == WCNT_LAST) begin
                    wcnt_d  = '0;
                    err_d   = 1'b1;
                    code_d  = ERR_TMO;
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        en_d  = (state_d == ST_ISSUE);
        rdy_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    // State and registered outputs; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            bcnt_q  <= 2'd0;
            wcnt_q  <= '0;
            op_q    <= ALU_ADD;
            a_lo_q  <= '0;
            a_hi_q  <= '0;
            b_lo_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= ALU_ADD;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            op_q    <= op_d;
            a_lo_q  <= a_lo_d;
            a_hi_q  <= a_hi_d;
            b_lo_q  <= b_lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            en_q    <= en_d;
            err_q   <= err_d;
            code_q  <= code_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.rx_ready     = rdy_q;
    assign bus.a            = a_q;
    assign bus.b            = b_q;
    assign bus.alu_fun      = alu_q;
    assign bus.arith_enable = en_q;
    assign bus.err          = err_q;
    assign bus.err_code     = code_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: directed frames plus randomized frames
// compared against a frame-level reference model.
module tb_operand_loader;

    localparam int DW = 16;
    localparam int BW = 8;
    localparam int WM = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    operand_loader_if #(.in_data_width(DW), .BYTE_W(BW)) bus();

    operand_loader #(.in_data_width(DW), .BYTE_W(BW), .WAIT_MAX(WM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: last issued operands and number of issues expected.
    logic [15:0] m_a  = 16'h0000;
    logic [15:0] m_b  = 16'h0000;
    logic [1:0]  m_op = 2'b00;
    int          m_issues = 0;

    int   en_seen = 0;
    logic both_seen = 1'b0;
    logic en_long = 1'b0;
    logic en_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor for enable pulse count/width and err/enable exclusivity.
    always @(negedge clk) begin
        if (bus.arith_enable === 1'b1) en_seen++;
        if (bus.arith_enable === 1'b1 && bus.err === 1'b1) both_seen = 1'b1;
        if (bus.arith_enable === 1'b1 && en_prev) en_long = 1'b1;
        en_prev = (bus.arith_enable === 1'b1);
    end

    // Present a byte after 'gap' idle cycles; returns at the negedge after acceptance.
    task automatic drive_byte(input logic [7:0] d, input int gap);
        int guard;
        for (int i = 0; i < gap; i++) begin
            bus.rx_valid   = 1'b0;
            bus.rx_data    = 8'($urandom);
            bus.arith_done = 1'($urandom);
            @(negedge clk);
        end
        bus.rx_valid   = 1'b1;
        bus.rx_data    = d;
        bus.arith_done = 1'($urandom);
        guard = 0;
        while (bus.rx_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check_eq("rx_ready_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [15:0] av, input logic [15:0] bv,
                             input int delay, input bit hold, input int gmax);
        logic [1:0] op;
        int k;
        op = cmd[1:0];
        drive_byte(cmd, $urandom_range(gmax, 0));
        if (cmd[7:4] != 4'hA) begin
            check_eq("hdr_err", 32'(bus.err), 32'd1);
            check_eq("hdr_code", 32'(bus.err_code), 32'd1);
            check_eq("hdr_no_en", 32'(bus.arith_enable), 32'd0);
            check_eq("hdr_idle_rdy", 32'(bus.rx_ready), 32'd1);
            @(negedge clk);
            check_eq("hdr_err_pulse", 32'(bus.err), 32'd0);
            return;
        end
        check_eq("cmd_no_err", 32'(bus.err), 32'd0);
        drive_byte(av[7:0],  $urandom_range(gmax, 0));
        drive_byte(av[15:8], $urandom_range(gmax, 0));
        drive_byte(bv[7:0],  $urandom_range(gmax, 0));
        drive_byte(bv[15:8], $urandom_range(gmax, 0));
        if (op == 2'b11 && bv == 16'h0000) begin
            check_eq("div0_err", 32'(bus.err), 32'd1);
            check_eq("div0_code", 32'(bus.err_code), 32'd2);
            check_eq("div0_no_en", 32'(bus.arith_enable), 32'd0);
            check_eq("div0_a_hold", 32'($unsigned(bus.a)), 32'(m_a));
            check_eq("div0_b_hold", 32'($unsigned(bus.b)), 32'(m_b));
            check_eq("div0_op_hold", 32'(bus.alu_fun), 32'(m_op));
            check_eq("div0_idle_rdy", 32'(bus.rx_ready), 32'd1);
            @(negedge clk);
            check_eq("div0_err_pulse", 32'(bus.err), 32'd0);
            return;
        end
        m_a = av;
        m_b = bv;
        m_op = op;
        m_issues++;
        check_eq("issue_en", 32'(bus.arith_enable), 32'd1);
        check_eq("issue_no_err", 32'(bus.err), 32'd0);
        check_eq("issue_a", 32'($unsigned(bus.a)), 32'(m_a));
        check_eq("issue_b", 32'($unsigned(bus.b)), 32'(m_b));
        check_eq("issue_op", 32'(bus.alu_fun), 32'(m_op));
        check_eq("issue_busy", 32'(bus.rx_ready), 32'd0);
        if (hold) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'($urandom);
        end
        bus.arith_done = 1'($urandom);
        @(negedge clk);
        check_eq("wait_en_low", 32'(bus.arith_enable), 32'd0);
        k = 0;
        while (1) begin
            bus.arith_done = (k == delay);
            check_eq("wait_busy", 32'(bus.rx_ready), 32'd0);
            @(negedge clk);
            bus.arith_done = 1'b0;
            if (k == delay) begin
                check_eq("done_no_err", 32'(bus.err), 32'd0);
                check_eq("done_idle", 32'(bus.rx_ready), 32'd1);
                break;
            end
            if (k == WM - 1) begin
                check_eq("tmo_err", 32'(bus.err), 32'd1);
                check_eq("tmo_code", 32'(bus.err_code), 32'd3);
                check_eq("tmo_idle", 32'(bus.rx_ready), 32'd1);
                break;
            end
            k++;
        end
        bus.rx_valid = 1'b0;
        check_eq("post_a", 32'($unsigned(bus.a)), 32'(m_a));
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [3:0]  nib;
        logic [15:0] bv;

        rst = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        bus.arith_done = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_rdy", 32'(bus.rx_ready), 32'd0);
        check_eq("rst_a", 32'($unsigned(bus.a)), 32'd0);
        check_eq("rst_b", 32'($unsigned(bus.b)), 32'd0);
        check_eq("rst_op", 32'(bus.alu_fun), 32'd0);
        check_eq("rst_en", 32'(bus.arith_enable), 32'd0);
        check_eq("rst_err", 32'(bus.err), 32'd0);
        check_eq("rst_code", 32'(bus.err_code), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_frame(8'hA1, 16'h0005, 16'h0003, 0, 1'b0, 0);
        run_frame(8'h53, 16'h0000, 16'h0000, 0, 1'b0, 0);
        run_frame(8'hA3, 16'h0010, 16'h0000, 0, 1'b0, 0);
        run_frame(8'hA2, 16'h1234, 16'h00FF, WM + 5, 1'b0, 0);
        run_frame(8'hA0, 16'h00AA, 16'h0055, 2, 1'b1, 3);

        // Reset after A_HI: partial frame must be discarded and outputs cleared.
        drive_byte(8'hA2, 0);
        drive_byte(8'h34, 0);
        drive_byte(8'h12, 0);
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_rdy", 32'(bus.rx_ready), 32'd0);
        check_eq("mid_rst_a", 32'($unsigned(bus.a)), 32'd0);
        check_eq("mid_rst_b", 32'($unsigned(bus.b)), 32'd0);
        check_eq("mid_rst_op", 32'(bus.alu_fun), 32'd0);
        m_a = 16'h0000;
        m_b = 16'h0000;
        m_op = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_frame(8'hA0, 16'hFFFF, 16'h0001, 0, 1'b1, 2);

        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(7, 0) == 0) begin
                nib = 4'($urandom);
                if (nib == 4'hA) nib = 4'h5;
                cmd = {nib, 4'($urandom)};
            end else begin
                cmd = {4'hA, 4'($urandom)};
            end
            bv = ($urandom_range(3, 0) == 0) ? 16'h0000 : 16'($urandom);
            run_frame(cmd, 16'($urandom), bv, $urandom_range(WM + 1, 0),
                      1'($urandom), 3);
        end

        @(negedge clk);
        check_eq("enable_count", 32'(en_seen), 32'(m_issues));
        check_eq("err_en_excl", 32'(both_seen), 32'd0);
        check_eq("enable_width", 32'(en_long), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
